// File: rtl/pcihellocore_keys_pkg.sv
// rtl/pcihellocore_keys_pkg.sv - shared constants for the key debounce/irq controller
package pcihellocore_keys_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_DIV  = 2'd3;

    localparam int CNT_W = 4;

    // A programmed divider of zero behaves as one: tick every cycle.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/pcihellocore_keys_debounce_bit.sv
// rtl/pcihellocore_keys_debounce_bit.sv - 2-FF synchroniser and tick-sampled debouncer for one key line
module pcihellocore_keys_debounce_bit
    import pcihellocore_keys_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    localparam logic             IDLE = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= IDLE;
            sync   <= IDLE;
            cnt    <= '0;
            stable <= IDLE;
        end else begin
            meta <= raw;
            sync <= meta;
            // Any sample matching the accepted level throws away progress.
            if (sync == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcihellocore_keys_ctrl.sv
// rtl/pcihellocore_keys_ctrl.sv - key debounce, press capture and irq as an Avalon-MM slave
module pcihellocore_keys_ctrl
    import pcihellocore_keys_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEBOUNCE_DIV   = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{ACTIVE_LOW}};

    logic              wr;
    logic [31:0]       div_reg;
    logic [31:0]       pcnt;
    logic              tick;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  pressed;
    logic [WIDTH-1:0]  pressed_q;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  w1c;
    logic [31:0]       rd_word;

    assign wr   = chipselect & ~write_n;
    assign tick = (pcnt == eff_div(div_reg) - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg <= 32'(DEBOUNCE_DIV);
            pcnt    <= '0;
        end else if (wr && address == ADDR_DIV) begin
            // Restart the sample period so the first tick lands DIV cycles out.
            div_reg <= writedata;
            pcnt    <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 32'd1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_keys_debounce_bit #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .raw     (in_port[i]),
            .stable  (stable[i])
        );
    end

    assign pressed = stable ^ IDLE_LEVEL;
    assign w1c     = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word[WIDTH-1:0] = pressed;
            ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_cap;
            default:   rd_word            = div_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed_q <= '0;
            edge_cap  <= '0;
            irq_mask  <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
        end else begin
            pressed_q <= pressed;
            // A new press in the same cycle as its clear keeps the bit set.
            edge_cap  <= (edge_cap & ~w1c) | (pressed & ~pressed_q);
            if (wr && address == ADDR_MASK)
                irq_mask <= writedata[WIDTH-1:0];
            irq      <= |(edge_cap & irq_mask);
            readdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_pcihellocore_keys_ctrl.sv
// tb/tb_pcihellocore_keys_ctrl.sv - randomized and directed bench for pcihellocore_keys_ctrl
module tb_pcihellocore_keys_ctrl;

    localparam int W  = 4;
    localparam int DV = 4;
    localparam int SS = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic [W-1:0] in_port = 4'hF;
    logic         irq;

    int n_checks = 0;
    int n_err = 0;
    bit checking = 1'b0;

    pcihellocore_keys_ctrl #(
        .WIDTH          (W),
        .DEBOUNCE_DIV   (DV),
        .STABLE_SAMPLES (SS),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: line delayed two cycles, key level accepted after SS
    // consecutive ticks of disagreement, press = accepted level low.
    logic [W-1:0] m_d1, m_d2, m_lvl, m_prev, m_edge, m_mask;
    int           m_run [W];
    logic [31:0]  m_div, m_pc, m_rd;
    logic         m_irq;

    always @(posedge clk or negedge reset_n) begin : model
        logic [W-1:0] pr;
        logic [W-1:0] clr;
        logic [31:0]  period;
        logic         tk;
        if (!reset_n) begin
            m_d1 <= 4'hF; m_d2 <= 4'hF; m_lvl <= 4'hF;
            m_prev <= '0; m_edge <= '0; m_mask <= '0;
            m_div <= DV; m_pc <= '0; m_rd <= '0; m_irq <= 1'b0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
        end else begin
            period = (m_div == 0) ? 32'd1 : m_div;
            tk     = (m_pc == period - 1);
            pr     = ~m_lvl;
            case (address)
                2'd0: m_rd <= {28'b0, pr};
                2'd1: m_rd <= {28'b0, m_mask};
                2'd2: m_rd <= {28'b0, m_edge};
                default: m_rd <= m_div;
            endcase
            m_irq  <= |(m_edge & m_mask);
            clr    = (chipselect && !write_n && address == 2'd2) ? writedata[W-1:0] : '0;
            m_edge <= (m_edge & ~clr) | (pr & ~m_prev);
            m_prev <= pr;
            m_d1   <= in_port;
            m_d2   <= m_d1;
            for (int i = 0; i < W; i++) begin
                if (m_d2[i] == m_lvl[i]) m_run[i] <= 0;
                else if (tk) begin
                    if (m_run[i] + 1 == SS) begin
                        m_lvl[i] <= m_d2[i];
                        m_run[i] <= 0;
                    end else m_run[i] <= m_run[i] + 1;
                end
            end
            if (chipselect && !write_n && address == 2'd3) begin
                m_div <= writedata; m_pc <= '0;
            end else if (tk) m_pc <= '0;
            else m_pc <= m_pc + 1;
            if (chipselect && !write_n && address == 2'd1) m_mask <= writedata[W-1:0];
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("rd_model", readdata, m_rd);
            check("irq_model", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        step(1);
        check(tag, readdata, exp);
    endtask

    task automatic reset_reads(input string tag);
        read_chk({tag, "_data"}, 2'd0, 32'd0);
        read_chk({tag, "_mask"}, 2'd1, 32'd0);
        read_chk({tag, "_edge"}, 2'd2, 32'd0);
        read_chk({tag, "_div"},  2'd3, 32'd4);
        check({tag, "_irq"}, {31'b0, irq}, 32'd0);
    endtask

    int hold [W];
    bit found;

    initial begin
        step(3);
        checking = 1'b1;
        reset_n = 1'b1;
        step(2);
        reset_reads("rst");
        step(30);
        read_chk("rst_noedge", 2'd2, 32'd0);

        // Clean press of key 0
        bus_write(2'd1, 32'h1);
        in_port[0] = 1'b0;
        step(40);
        read_chk("press_data", 2'd0, 32'h1);
        read_chk("press_edge", 2'd2, 32'h1);
        check("press_irq", {31'b0, irq}, 32'd1);

        // Bounce on key 1 never outlasts three ticks
        for (int k = 0; k < 12; k++) begin
            in_port[1] = ~in_port[1];
            step(5);
        end
        in_port[1] = 1'b1;
        step(30);
        read_chk("bounce_data", 2'd0, 32'h1);
        read_chk("bounce_edge", 2'd2, 32'h1);

        // W1C then clear colliding with a fresh capture
        bus_write(2'd2, 32'h1);
        read_chk("w1c_edge", 2'd2, 32'h0);
        check("w1c_irq", {31'b0, irq}, 32'd0);
        in_port[0] = 1'b1;
        step(30);
        read_chk("release_data", 2'd0, 32'h0);
        read_chk("release_edge", 2'd2, 32'h0);
        in_port[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            if (!m_lvl[0] && !m_prev[0]) found = 1'b1;
            else step(1);
        end
        check("collide_found", {31'b0, found}, 32'd1);
        bus_write(2'd2, 32'h1);
        read_chk("collide_edge", 2'd2, 32'h1);
        bus_write(2'd2, 32'hF);

        // Masked capture, then unmask
        bus_write(2'd1, 32'h0);
        in_port[2] = 1'b0;
        step(40);
        read_chk("mask_edge", 2'd2, 32'h4);
        check("mask_irq_off", {31'b0, irq}, 32'd0);
        bus_write(2'd1, 32'h4);
        check("mask_irq_lat", {31'b0, irq}, 32'd0);
        step(1);
        check("mask_irq_on", {31'b0, irq}, 32'd1);
        in_port = 4'hF;
        step(30);
        bus_write(2'd2, 32'hF);

        // DIV=0 fast debounce, then reset in the middle of a press
        bus_write(2'd3, 32'h0);
        read_chk("div0_rd", 2'd3, 32'h0);
        in_port[3] = 1'b0;
        step(10);
        read_chk("div0_data", 2'd0, 32'h8);
        in_port[3] = 1'b1;
        step(10);
        read_chk("div0_release", 2'd0, 32'h0);
        in_port[3] = 1'b0;
        step(3);
        reset_n = 1'b0;
        in_port = 4'hF;
        step(3);
        reset_n = 1'b1;
        step(20);
        reset_reads("midrst");

        // Randomized traffic
        for (int i = 0; i < W; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    in_port[i] = ~in_port[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 60);
                end else hold[i]--;
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = (address == 2'd3) ? 32'($urandom_range(0, 5)) : $urandom;
            step(1);
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
